// File: rtl/vga_timing.sv
// Parametrised VGA raster timing generator: stage-0 coordinates, tile commands and
// sync/blank, with sync/de delayed PIPE cycles to match the downstream pixel pipeline.
module vga_timing #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned H_SYNC_END   = 720,
  parameter int unsigned H_TOTAL      = 840,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_SYNC_START = 481,
  parameter int unsigned V_SYNC_END   = 484,
  parameter int unsigned V_TOTAL      = 500,
  parameter bit          HS_NEG       = 1'b1,
  parameter bit          VS_NEG       = 1'b1,
  parameter int unsigned CW           = 10,
  parameter int unsigned PIPE         = 1,
  parameter int unsigned FW           = 26
) (
  input  logic          vga_clk,
  input  logic          reset_n,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [1:0]    command,
  output logic          active,
  output logic          sof,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_de,
  output logic [FW-1:0] frame
);

  localparam logic [1:0] CMD_IDLE    = 2'd0;
  localparam logic [1:0] CMD_RESTART = 2'd1;
  localparam logic [1:0] CMD_STEPY   = 2'd2;
  localparam logic [1:0] CMD_STEPX   = 2'd3;

  // One spare bit so a sync end equal to 2^CW still compares correctly.
  localparam logic [CW:0] H_ACT = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SS  = (CW+1)'(H_SYNC_START);
  localparam logic [CW:0] H_SE  = (CW+1)'(H_SYNC_END);
  localparam logic [CW:0] H_LST = (CW+1)'(H_TOTAL - 1);
  localparam logic [CW:0] V_ACT = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SS  = (CW+1)'(V_SYNC_START);
  localparam logic [CW:0] V_SE  = (CW+1)'(V_SYNC_END);
  localparam logic [CW:0] V_LST = (CW+1)'(V_TOTAL - 1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = {HS_NEG, VS_NEG, 1'b0};

  logic [CW:0] xe;
  logic [CW:0] ye;
  logic        line_end;
  logic        frame_end;
  sync_t       raw;
  sync_t       pipe_q [PIPE];

  assign xe        = {1'b0, x};
  assign ye        = {1'b0, y};
  assign line_end  = (xe == H_LST);
  assign frame_end = (ye == V_LST);

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      x     <= '0;
      y     <= '0;
      frame <= '0;
    end else if (line_end) begin
      x <= '0;
      if (frame_end) begin
        y     <= '0;
        frame <= frame + FW'(1);
      end else begin
        y <= y + CW'(1);
      end
    end else begin
      x <= x + CW'(1);
    end
  end

  assign active = (xe < H_ACT) && (ye < V_ACT);
  assign sof    = (x == '0) && (y == '0);

  // Restart is held for the whole first blanking line; tiles treat repeats as no-ops.
  always_comb begin
    command = CMD_IDLE;
    if (ye == V_ACT)      command = CMD_RESTART;
    else if (xe == H_ACT) command = CMD_STEPY;
    else if (active)      command = CMD_STEPX;
  end

  always_comb begin
    raw.hs = HS_NEG ^ ((xe >= H_SS) && (xe < H_SE));
    raw.vs = VS_NEG ^ ((ye >= V_SS) && (ye < V_SE));
    raw.de = active;
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(PIPE); i++) pipe_q[i] <= SYNC_IDLE;
    end else begin
      pipe_q[0] <= raw;
      for (int i = 1; i < int'(PIPE); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign vga_hs = pipe_q[PIPE-1].hs;
  assign vga_vs = pipe_q[PIPE-1].vs;
  assign vga_de = pipe_q[PIPE-1].de;

endmodule
